// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multiply/divide unit producing the HI/LO write-back
//
// Multiplies in one cycle. Multiply-accumulate takes two cycles and is built
// only when MULDIV_MADD_EN is defined. Divides use a 32-step restoring divider.
//
// Ports:
//   Clk, Rst_n         clock, synchronous active-low reset
//   aluop_i            opcode held in ID/EX
//   reg1_i, reg2_i     rs (dividend/multiplicand), rt (divisor/multiplier)
//   hi_i, lo_i         current HI/LO, already forwarded
//   flush_i            exception flush, aborts any operation in flight
//   hi_o, lo_o         HI/LO write-back value (zero when whilo_o is low)
//   whilo_o            HI/LO write enable
//   stallreq_o         stall request to the pipeline controller
module ex_muldiv (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
`ifdef MULDIV_MADD_EN
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
`endif

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;

  logic        is_div, is_divs;
  logic [63:0] smul, umul;
  logic [31:0] abs1, abs2;
  logic [32:0] rem_sh;
  logic [33:0] rem_diff;
  logic [31:0] quo_fix, rem_fix;

  assign is_divs = (aluop_i == EXE_DIV_OP);
  assign is_div  = is_divs || (aluop_i == EXE_DIVU_OP);

  assign smul = 64'($signed(reg1_i)) * 64'($signed(reg2_i));
  assign umul = 64'(reg1_i) * 64'(reg2_i);

  // Magnitudes for the signed divide; 0x80000000 stays 0x80000000, which is
  // the correct unsigned magnitude.
  assign abs1 = (is_divs && reg1_i[31]) ? -reg1_i : reg1_i;
  assign abs2 = (is_divs && reg2_i[31]) ? -reg2_i : reg2_i;

  // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
  // The extra top bit of rem_diff is the borrow (negative result).
  assign rem_sh   = {rem_q, quo_q[31]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, dvsr_q};

  // Signs are latched only for DIV, so DIVU never gets corrected.
  assign quo_fix = (sign1_q ^ sign2_q) ? -quo_q : quo_q;
  assign rem_fix = sign1_q ? -rem_q : rem_q;

`ifdef MULDIV_MADD_EN
  logic [63:0] mul_tmp_q, mul_tmp_d;
  logic        madd_cnt_q, madd_cnt_d;
  logic        is_madd, is_msub, madd_signed;
  assign is_madd     = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP);
  assign is_msub     = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign madd_signed = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi_i, lo_i};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
`ifdef MULDIV_MADD_EN
    mul_tmp_d  = mul_tmp_q;
    madd_cnt_d = 1'b0;
`endif

    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          stallreq_o = 1'b1;
          if (reg2_i == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            rem_d   = 32'd0;
            quo_d   = abs1;
            dvsr_d  = abs2;
            cnt_d   = 5'd0;
            sign1_d = is_divs & reg1_i[31];
            sign2_d = is_divs & reg2_i[31];
          end
        end else if (aluop_i == EXE_MULT_OP) begin
          {hi_o, lo_o} = smul;
          whilo_o      = 1'b1;
        end else if (aluop_i == EXE_MULTU_OP) begin
          {hi_o, lo_o} = umul;
          whilo_o      = 1'b1;
        end
`ifdef MULDIV_MADD_EN
        else if (is_madd || is_msub) begin
          if (!madd_cnt_q) begin
            mul_tmp_d  = madd_signed ? smul : umul;
            madd_cnt_d = 1'b1;
            stallreq_o = 1'b1;
          end else begin
            {hi_o, lo_o} = is_madd ? ({hi_i, lo_i} + mul_tmp_q)
                                   : ({hi_i, lo_i} - mul_tmp_q);
            whilo_o      = 1'b1;
          end
        end
`endif
      end
      DIV_BY_ZERO: begin
        stallreq_o = 1'b1;
        rem_d      = 32'd0;
        quo_d      = 32'd0;
        sign1_d    = 1'b0;
        sign2_d    = 1'b0;
        state_d    = DIV_END;
      end
      DIV_ON: begin
        stallreq_o = 1'b1;
        rem_d      = rem_diff[33] ? rem_sh[31:0] : rem_diff[31:0];
        quo_d      = {quo_q[30:0], ~rem_diff[33]};
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_END;
      end
      DIV_END: begin
        hi_o    = rem_fix;
        lo_o    = quo_fix;
        whilo_o = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // Flush (and reset) kill the write and the stall in the same cycle so no
    // partial result ever reaches HI/LO.
    if (flush_i || !Rst_n) begin
      state_d    = DIV_IDLE;
      cnt_d      = 5'd0;
      hi_o       = 32'd0;
      lo_o       = 32'd0;
      whilo_o    = 1'b0;
      stallreq_o = 1'b0;
`ifdef MULDIV_MADD_EN
      mul_tmp_d  = 64'd0;
      madd_cnt_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvsr_q     <= 32'd0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
      mul_tmp_q  <= 64'd0;
      madd_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
`ifdef MULDIV_MADD_EN
      mul_tmp_q  <= mul_tmp_d;
      madd_cnt_q <= madd_cnt_d;
`endif
    end
  end

endmodule
